data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Load/store front-end sitting directly upstream of the Lattice data memory wrapper.
- Accepts one core memory request at a time (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) and checks alignment, range and funct3.
- Drives the memory's 14-bit word address, write enable, byte mask and replicated write data.
- Waits the memory's synchronous read latency, then returns aligned, sign- or zero-extended load data or an error to the core.

Parameters:
- ADDR_BITS, 14, word-address width presented to the data memory.
- DATA_BASE, 32'h2000_0000, byte base address of the data region; region size is 4*2^ADDR_BITS bytes.
- READ_LATENCY, 1, cycles from address presentation to valid mem_rdata; legal values 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request strobe
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the access
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid
- resp_fault  out  1  out-of-range or illegal funct3; valid with resp_valid
- bus_address  out  ADDR_BITS  memory word address
- write_enable  out  1  memory write strobe
- mem_mask  out  4  byte-lane enables, bit i = byte i
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_misaligned=0, resp_fault=0.
  - bus_address=0, write_enable=0, mem_mask=0, mem_wdata=0.
  - Any in-flight access is abandoned and produces no response.
- States: IDLE, WRITE, READ, ERR.
- Handshake:
  - req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready.
  - req_* is registered on acceptance; the core need not hold it afterwards.
  - There is no response backpressure: resp_valid is asserted for exactly one cycle.
- Decode at acceptance, evaluated in this order:
  - fault if off = req_addr - DATA_BASE (32-bit unsigned) >= 4*2^ADDR_BITS, or funct3 is illegal. Legal loads: 0,1,2,4,5; legal stores: 0,1,2.
  - else misaligned if a halfword has addr[0]=1, or a word has addr[1:0]!=0.
  - Either error goes to ERR.
  - else a store goes to WRITE; a load goes to READ with cnt=READ_LATENCY.
- bus_address = off[ADDR_BITS+1:2], registered at acceptance of a valid access; it holds its last value otherwise.
- WRITE (1 cycle):
  - write_enable=1.
  - mem_mask: SB 4'b0001<<a[1:0]; SH 4'b0011<<a[1:0]; SW 4'b1111.
  - mem_wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
  - resp_valid=1 in the same cycle; then go to IDLE.
  - Store response latency = 1 cycle after acceptance.
- READ:
  - write_enable=0, mem_mask=0.
  - cnt decrements each cycle.
  - In the cycle cnt reaches 0, mem_rdata is sampled through the lsu_load_align combinational path.
  - resp_rdata and resp_valid are registered and appear the next cycle; then go to IDLE.
  - Load response latency = READ_LATENCY+1 cycles after acceptance.
- lsu_load_align:
  - Selects byte a[1:0] or halfword a[1].
  - funct3 0/1 sign-extend; 4/5 zero-extend; 2 passes the word.
- ERR (1 cycle): resp_valid=1 with the matching flag set, resp_rdata=0; no memory strobe. Then go to IDLE.
- Simultaneous events:
  - A request arriving in the response cycle waits (req_ready=0) and is accepted on the following IDLE cycle.
  - Max throughput: one store per 2 cycles; one load per READ_LATENCY+2 cycles.
- write_enable and mem_mask are glitch-free register outputs, never combinational from req_*.

Decomposition:
- Shared package (riscV_unrn_pkg):
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_e enum.
  - DATA_BASE default constant.
- One sub-module: lsu_load_align (funct3, byte offset, 32-bit word in -> 32-bit extended out), purely combinational.

Test Plan:
- Reset: rst low mid-READ -> all outputs 0 immediately; after release req_ready=1; no stale resp_valid.
- SB at 0x2000_0006, wdata 0x0000_00A5 -> 1 cycle later: write_enable=1, bus_address=1, mem_mask=0100, mem_wdata=0xA5A5A5A5, resp_valid=1.
- LB at 0x2000_0007 with mem_rdata 0x80FF_1234, READ_LATENCY=1 -> resp at cycle 2: resp_rdata=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LH at 0x2000_0002 -> 0xFFFF_80FF.
- LW at 0x2000_0002 -> resp_misaligned=1, resp_rdata=0, no write_enable, 1-cycle latency. SH at 0x2000_0001 -> misaligned.
- LW at 0x2001_0000 (ADDR_BITS=14) -> resp_fault=1. Store with funct3=4 -> resp_fault=1; the memory is never written.
- Back-to-back SW then LW to the same address with READ_LATENCY=2: req_valid held high -> second request accepted on the cycle after the store response. Load returns the stored word 3 cycles after its acceptance.

Source files
------------

// File: rtl/data_mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// Module : riscV_unrn_pkg
// Brief  : Shared funct3 constants, LSU state enum and data-region defaults.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscV_unrn_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h2000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ERR   = 2'd3
    } lsu_state_e;

    // Stores only have byte/half/word widths; loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_lsu_if.sv
// ---------------------------------------------------------------------------
// Module : data_mem_lsu_if
// Brief  : Core-side request/response handshake of the load/store unit.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
    );
endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// Module : lsu_load_align
// Brief  : Combinational byte/halfword select with sign or zero extension.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
    import riscV_unrn_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = word >> {byte_off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_lsu.sv
// ---------------------------------------------------------------------------
// Module : data_mem_lsu
// Brief  : Single-outstanding load/store front-end for the data memory.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_lsu
    import riscV_unrn_pkg::*;
#(
    parameter int          ADDR_BITS    = 14,
    parameter logic [31:0] DATA_BASE    = DATA_BASE_DEFAULT,
    parameter int          READ_LATENCY = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    data_mem_lsu_if.slave        core,
    output logic [ADDR_BITS-1:0] bus_address,
    output logic                 write_enable,
    output logic [3:0]           mem_mask,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int          CNT_W  = $clog2(READ_LATENCY + 1);
    localparam logic [32:0] REGION = 33'd4 << ADDR_BITS;

    lsu_state_e           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           acc_funct3, funct3_nxt;
    logic [1:0]           acc_byte, byte_nxt;
    logic [ADDR_BITS-1:0] bus_nxt;
    logic                 we_nxt;
    logic [3:0]           mask_nxt;
    logic [31:0]          wdata_nxt;
    logic                 resp_valid, rv_nxt;
    logic [31:0]          resp_rdata, rdata_nxt;
    logic                 resp_mis, mis_nxt;
    logic                 resp_fault, fault_nxt;

    logic [31:0]          off;
    logic                 dec_fault;
    logic                 dec_mis;
    logic [31:0]          aligned;

    lsu_load_align u_align (
        .funct3   (acc_funct3),
        .byte_off (acc_byte),
        .word     (mem_rdata),
        .data     (aligned)
    );

    // Range check uses a 33-bit compare so the region may span the full space.
    always_comb begin
        off       = core.req_addr - DATA_BASE;
        dec_fault = ({1'b0, off} >= REGION) || !f3_legal(core.req_we, core.req_funct3);
        dec_mis   = ((core.req_funct3[1:0] == 2'b01) && off[0]) ||
                    ((core.req_funct3[1:0] == 2'b10) && (off[1:0] != 2'b00));
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        funct3_nxt = acc_funct3;
        byte_nxt   = acc_byte;
        bus_nxt    = bus_address;
        we_nxt     = 1'b0;
        mask_nxt   = 4'b0000;
        wdata_nxt  = mem_wdata;
        rv_nxt     = 1'b0;
        rdata_nxt  = 32'h0;
        mis_nxt    = 1'b0;
        fault_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (core.req_valid) begin
                    funct3_nxt = core.req_funct3;
                    byte_nxt   = off[1:0];
                    if (dec_fault) begin
                        state_nxt = ST_ERR;
                        rv_nxt    = 1'b1;
                        fault_nxt = 1'b1;
                    end else if (dec_mis) begin
                        state_nxt = ST_ERR;
                        rv_nxt    = 1'b1;
                        mis_nxt   = 1'b1;
                    end else begin
                        bus_nxt = off[ADDR_BITS+1:2];
                        if (core.req_we) begin
                            state_nxt = ST_WRITE;
                            we_nxt    = 1'b1;
                            rv_nxt    = 1'b1;
                            case (core.req_funct3)
                                F3_B: begin
                                    mask_nxt  = 4'b0001 << off[1:0];
                                    wdata_nxt = {4{core.req_wdata[7:0]}};
                                end
                                F3_H: begin
                                    mask_nxt  = 4'b0011 << off[1:0];
                                    wdata_nxt = {2{core.req_wdata[15:0]}};
                                end
                                default: begin
                                    mask_nxt  = 4'b1111;
                                    wdata_nxt = core.req_wdata;
                                end
                            endcase
                        end else begin
                            state_nxt = ST_READ;
                            cnt_nxt   = CNT_W'(READ_LATENCY);
                        end
                    end
                end
            end
            ST_READ: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                // Capture on the last count so the registered response lands as cnt hits 0.
                if (cnt == CNT_W'(1)) begin
                    rv_nxt    = 1'b1;
                    rdata_nxt = aligned;
                end
                if (cnt == '0) state_nxt = ST_IDLE;
            end
            ST_WRITE: state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            acc_funct3   <= 3'b000;
            acc_byte     <= 2'b00;
            bus_address  <= '0;
            write_enable <= 1'b0;
            mem_mask     <= 4'b0000;
            mem_wdata    <= 32'h0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_mis     <= 1'b0;
            resp_fault   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            acc_funct3   <= funct3_nxt;
            acc_byte     <= byte_nxt;
            bus_address  <= bus_nxt;
            write_enable <= we_nxt;
            mem_mask     <= mask_nxt;
            mem_wdata    <= wdata_nxt;
            resp_valid   <= rv_nxt;
            resp_rdata   <= rdata_nxt;
            resp_mis     <= mis_nxt;
            resp_fault   <= fault_nxt;
        end
    end

    assign core.req_ready       = (state == ST_IDLE);
    assign core.resp_valid      = resp_valid;
    assign core.resp_rdata      = resp_rdata;
    assign core.resp_misaligned = resp_mis;
    assign core.resp_fault      = resp_fault;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
// ---------------------------------------------------------------------------
// Module : tb_data_mem_lsu
// Brief  : Self-checking bench: vector table plus reset and back-to-back runs.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_lsu;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic [13:0] baddr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic [13:0] baddr;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q1[$];
    exp_t q2[$];

    data_mem_lsu_if if1();
    data_mem_lsu_if if2();

    logic [13:0] ba1, ba2;
    logic        we1, we2;
    logic [3:0]  mk1, mk2;
    logic [31:0] wd1, wd2, rd1, rd2;
    logic [31:0] mem1 [16384];
    logic [31:0] mem2 [16384];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_lsu #(.ADDR_BITS(14), .DATA_BASE(32'h2000_0000), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .core(if1), .bus_address(ba1), .write_enable(we1),
        .mem_mask(mk1), .mem_wdata(wd1), .mem_rdata(rd1)
    );

    data_mem_lsu #(.ADDR_BITS(14), .DATA_BASE(32'h2000_0000), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .core(if2), .bus_address(ba2), .write_enable(we2),
        .mem_mask(mk2), .mem_wdata(wd2), .mem_rdata(rd2)
    );

    // Memory models: latency 1 reads the presented address directly, latency 2 adds a stage.
    assign rd1 = mem1[ba1];
    always @(posedge clk) begin
        rd2 <= mem2[ba2];
        for (int b = 0; b < 4; b++) begin
            if (we1 && mk1[b]) mem1[ba1][b*8 +: 8] <= wd1[b*8 +: 8];
            if (we2 && mk2[b]) mem2[ba2][b*8 +: 8] <= wd2[b*8 +: 8];
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void check_resp(string tag, exp_t e, logic [31:0] rdata, logic mis,
                                       logic fault, logic we, logic [3:0] mask,
                                       logic [31:0] wd, logic [13:0] ba);
        chk({tag, " latency"}, 32'(cyc), 32'(e.cyc));
        chk({tag, " resp_rdata"}, rdata, e.rdata);
        chk({tag, " resp_misaligned"}, 32'(mis), 32'(e.mis));
        chk({tag, " resp_fault"}, 32'(fault), 32'(e.fault));
        chk({tag, " write_enable"}, 32'(we), 32'(e.we));
        if (e.we) begin
            chk({tag, " mem_mask"}, 32'(mask), 32'(e.mask));
            chk({tag, " mem_wdata"}, wd, e.mwdata);
            chk({tag, " bus_address"}, 32'(ba), 32'(e.baddr));
        end
    endfunction

    always @(negedge clk) begin
        if (rst && if1.resp_valid) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut1 unexpected resp_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                check_resp("dut1", q1.pop_front(), if1.resp_rdata, if1.resp_misaligned,
                           if1.resp_fault, we1, mk1, wd1, ba1);
            end
        end
        if (rst && if2.resp_valid) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut2 unexpected resp_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                check_resp("dut2", q2.pop_front(), if2.resp_rdata, if2.resp_misaligned,
                           if2.resp_fault, we2, mk2, wd2, ba2);
            end
        end
    end

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic mis, logic fault, logic [3:0] mask,
                                logic [31:0] mwdata, logic [13:0] baddr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.mis = mis; v.fault = fault; v.mask = mask; v.mwdata = mwdata; v.baddr = baddr;
        return v;
    endfunction

    task automatic drain(input int which);
        int n = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (((which == 1) ? q1.size() : q2.size()) != 0) begin
            tests++; fails++;
            $display("FAIL dut%0d response timeout: got none expected resp_valid", which);
            if (which == 1) q1.delete(); else q2.delete();
        end
    endtask

    task automatic apply1(input vec_t v);
        exp_t e;
        int   lat;
        @(negedge clk);
        if1.req_valid  = 1'b1;
        if1.req_we     = v.we;
        if1.req_funct3 = v.f3;
        if1.req_addr   = v.addr;
        if1.req_wdata  = v.wdata;
        lat      = (v.we || v.mis || v.fault) ? 1 : 2;
        e.rdata  = v.rdata;
        e.mis    = v.mis;
        e.fault  = v.fault;
        e.we     = v.we && !v.mis && !v.fault;
        e.mask   = v.mask;
        e.mwdata = v.mwdata;
        e.baddr  = v.baddr;
        e.cyc    = cyc + lat;
        q1.push_back(e);
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        drain(1);
    endtask

    vec_t vecs[$];

    initial begin
        exp_t e;
        int   k;

        for (int i = 0; i < 16384; i++) begin
            mem1[i] = 32'h0;
            mem2[i] = 32'h0;
        end
        mem1[0] = 32'h80FF_1234;
        mem1[1] = 32'h80FF_1234;

        vecs.push_back(mk(1, 3'd0, 32'h2000_0006, 32'h0000_00A5, 32'h0, 0, 0, 4'b0100, 32'hA5A5_A5A5, 14'd1));
        vecs.push_back(mk(0, 3'd0, 32'h2000_0007, 32'h0, 32'hFFFF_FF80, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd4, 32'h2000_0007, 32'h0, 32'h0000_0080, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd1, 32'h2000_0002, 32'h0, 32'hFFFF_80FF, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd5, 32'h2000_0000, 32'h0, 32'h0000_1234, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd2, 32'h2000_0004, 32'h0, 32'h80A5_1234, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd0, 32'h2000_0005, 32'h0, 32'h0000_0012, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd2, 32'h2000_0002, 32'h0, 32'h0, 1, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(1, 3'd1, 32'h2000_0001, 32'h5555_5555, 32'h0, 1, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd5, 32'h2000_0003, 32'h0, 32'h0, 1, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd2, 32'h2001_0000, 32'h0, 32'h0, 0, 1, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd2, 32'h2001_0002, 32'h0, 32'h0, 0, 1, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd0, 32'h1FFF_FFFF, 32'h0, 32'h0, 0, 1, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(1, 3'd4, 32'h2000_0008, 32'hDEAD_BEEF, 32'h0, 0, 1, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd3, 32'h2000_0000, 32'h0, 32'h0, 0, 1, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd6, 32'h2000_0000, 32'h0, 32'h0, 0, 1, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(0, 3'd2, 32'h2000_0008, 32'h0, 32'h0, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(1, 3'd1, 32'h2000_000A, 32'h1234_BEEF, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 14'd2));
        vecs.push_back(mk(0, 3'd1, 32'h2000_000A, 32'h0, 32'hFFFF_BEEF, 0, 0, 4'b0, 32'h0, 14'd0));
        vecs.push_back(mk(1, 3'd2, 32'h2000_FFFC, 32'h1234_5678, 32'h0, 0, 0, 4'b1111, 32'h1234_5678, 14'h3FFF));
        vecs.push_back(mk(0, 3'd2, 32'h2000_FFFC, 32'h0, 32'h1234_5678, 0, 0, 4'b0, 32'h0, 14'd0));

        if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_funct3 = 3'd0;
        if1.req_addr = 32'h0; if1.req_wdata = 32'h0;
        if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_funct3 = 3'd0;
        if2.req_addr = 32'h0; if2.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(if1.req_ready), 32'd1);
        chk("reset resp_valid", 32'(if1.resp_valid), 32'd0);
        chk("reset write_enable", 32'(we1), 32'd0);
        chk("reset mem_mask", 32'(mk1), 32'd0);
        chk("reset bus_address", 32'(ba1), 32'd0);
        rst = 1'b1;
        #1;

        foreach (vecs[i]) apply1(vecs[i]);

        // Reset asserted while a load is still waiting on memory.
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_we = 1'b0; if1.req_funct3 = 3'd2;
        if1.req_addr = 32'h2000_0004;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midread resp_valid", 32'(if1.resp_valid), 32'd0);
        chk("midread resp_rdata", if1.resp_rdata, 32'd0);
        chk("midread resp_flags", 32'({if1.resp_misaligned, if1.resp_fault}), 32'd0);
        chk("midread bus_address", 32'(ba1), 32'd0);
        chk("midread write_enable", 32'(we1), 32'd0);
        chk("midread mem_mask", 32'(mk1), 32'd0);
        chk("midread mem_wdata", wd1, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post-reset req_ready", 32'(if1.req_ready), 32'd1);
        repeat (4) @(negedge clk);

        // Back-to-back SW then LW with req_valid held, read latency 2.
        @(negedge clk);
        k = cyc;
        if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_funct3 = 3'd2;
        if2.req_addr = 32'h2000_0010; if2.req_wdata = 32'hCAFE_F00D;
        e = '{rdata: 32'h0, mis: 1'b0, fault: 1'b0, we: 1'b1, mask: 4'b1111,
              mwdata: 32'hCAFE_F00D, baddr: 14'd4, cyc: k + 1};
        q2.push_back(e);
        @(negedge clk);
        chk("b2b req_ready in store resp", 32'(if2.req_ready), 32'd0);
        if2.req_we = 1'b0; if2.req_wdata = 32'h0;
        e = '{rdata: 32'hCAFE_F00D, mis: 1'b0, fault: 1'b0, we: 1'b0, mask: 4'b0,
              mwdata: 32'h0, baddr: 14'd0, cyc: k + 5};
        q2.push_back(e);
        @(negedge clk);
        chk("b2b req_ready before load accept", 32'(if2.req_ready), 32'd1);
        @(posedge clk); #1;
        if2.req_valid = 1'b0;
        drain(2);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
